// File: rtl/uart_out_demux_if.sv
// Bundle of the USB RX FIFO read port and the per-UART TX FIFO write ports
// seen by the USB -> UART demultiplexer.
interface uart_out_demux_if #(
    parameter int DATA_BITS    = 8,
    parameter int COUNTER_BITS = 16,
    parameter int UART_COUNT   = 1
);
    logic                    fifo_empty;
    logic                    fifo_read;
    logic [DATA_BITS-1:0]    fifo_data;
    logic [UART_COUNT-1:0]   full;
    logic [UART_COUNT-1:0]   write;
    logic [DATA_BITS-1:0]    tx_data;
    logic [COUNTER_BITS-1:0] drop_count;

    modport master (
        input  fifo_empty, fifo_data, full,
        output fifo_read, write, tx_data, drop_count
    );

    modport slave (
        output fifo_empty, fifo_data, full,
        input  fifo_read, write, tx_data, drop_count
    );
endinterface

// File: rtl/uart_out_demux.sv
// Pops (index, value) byte pairs from the USB RX FIFO and writes each value
// to the TX FIFO of UART[index]; pairs with an out-of-range index are counted and dropped.
module uart_out_demux #(
    parameter int DATA_BITS    = 8,
    parameter int COUNTER_BITS = 16,
    parameter int UART_COUNT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_out_demux_if.master  bus
);

    typedef enum logic [1:0] {
        ST_INDEX     = 2'd0,
        ST_INDEX_POP = 2'd1,
        ST_VALUE     = 2'd2,
        ST_VALUE_POP = 2'd3
    } state_t;

    state_t                  state_r;
    logic [DATA_BITS-1:0]    index_r;
    logic                    fifo_read_r;
    logic [UART_COUNT-1:0]   write_r;
    logic [DATA_BITS-1:0]    tx_data_r;
    logic [COUNTER_BITS-1:0] drop_count_r;

    logic [UART_COUNT-1:0]   target_onehot_s;
    logic                    target_full_s;
    logic                    target_valid_s;

    // Decode the stored index over its full width; an index beyond the last UART matches nothing.
    always_comb begin
        target_onehot_s = '0;
        target_full_s   = 1'b0;
        for (int i = 0; i < UART_COUNT; i++) begin
            if ({1'b0, index_r} == (DATA_BITS+1)'(i)) begin
                target_onehot_s[i] = 1'b1;
                target_full_s      = bus.full[i];
            end else begin
                target_onehot_s[i] = target_onehot_s[i];
            end
        end
        target_valid_s = |target_onehot_s;
    end

    // Pair-parsing FSM; strobes are single-cycle and default back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_INDEX;
            index_r      <= '0;
            fifo_read_r  <= 1'b0;
            write_r      <= '0;
            tx_data_r    <= '0;
            drop_count_r <= '0;
        end else begin
            fifo_read_r <= 1'b0;
            write_r     <= '0;
            tx_data_r   <= '0;
            case (state_r)
                ST_INDEX: begin
                    if (!bus.fifo_empty) begin
                        index_r     <= bus.fifo_data;
                        fifo_read_r <= 1'b1;
                        state_r     <= ST_INDEX_POP;
                    end else begin
                        state_r <= ST_INDEX;
                    end
                end
                ST_INDEX_POP: begin
                    state_r <= ST_VALUE;
                end
                ST_VALUE: begin
                    if (bus.fifo_empty) begin
                        state_r <= ST_VALUE;
                    end else if (!target_valid_s) begin
                        fifo_read_r <= 1'b1;
                        if (drop_count_r != '1) begin
                            drop_count_r <= drop_count_r + COUNTER_BITS'(1);
                        end else begin
                            drop_count_r <= drop_count_r;
                        end
                        state_r <= ST_VALUE_POP;
                    end else if (target_full_s) begin
                        // Head-of-line block: nothing behind this pair may pass it.
                        state_r <= ST_VALUE;
                    end else begin
                        fifo_read_r <= 1'b1;
                        write_r     <= target_onehot_s;
                        tx_data_r   <= bus.fifo_data;
                        state_r     <= ST_VALUE_POP;
                    end
                end
                ST_VALUE_POP: begin
                    state_r <= ST_INDEX;
                end
                default: begin
                    state_r <= ST_INDEX;
                end
            endcase
        end
    end

    assign bus.fifo_read  = fifo_read_r;
    assign bus.write      = write_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.drop_count = drop_count_r;

endmodule
